// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch entry type for the fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 5;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with wrapping read/write pointers.
// Clear has priority over push/pop. Push while full is accepted only when a
// pop frees the head slot in the same cycle.
import fetch_pkg::*;

module fetch_fifo #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Per-entry storage registers
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues ROM reads at pc_in, captures the returned
// word one cycle later and buffers {pc, inst} pairs for decode. Issue is
// credit based (buffered + in-flight must stay within DEPTH), so the FIFO
// can never overflow. A flush cancels the in-flight read and empties the
// buffer at the next edge.
import fetch_pkg::*;

module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    credit_used;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign dec_valid = ~empty;
    assign pop       = dec_valid & dec_ready;

    // Entries already owed to the buffer once this cycle's pop retires.
    // count >= pop always, so this never underflows.
    assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight_v_q) - (CNT_W+1)'(pop);

    // rst gates issue so the request outputs are low while reset is held.
    assign issue      = rst & ~flush & (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req   = issue;
    assign pc_advance = issue;
    assign imem_addr  = pc_in;

    // ROM data for the previous request lands now; a flush drops it.
    assign push       = inflight_v_q & ~flush;
    assign push_entry = '{pc: inflight_pc_q, inst: imem_rdata};

    // Head is forced to zero when nothing is buffered.
    assign dec_inst = dec_valid ? head_entry.inst : '0;
    assign dec_pc   = dec_valid ? head_entry.pc   : '0;

    // In-flight tracking: a new request replaces the old one, otherwise it retires
    always_comb begin
        inflight_v_d  = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_pc_d = pc_in;
        end
    end

    // In-flight request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop & ~flush),
        .clear   (flush),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .count   (count),
        .empty   (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register model and a registered ROM
// whose word at index i is 0xA000_0000 + i.
import fetch_pkg::*;

module tb_fetch_unit;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_advance;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              dec_valid;
    logic              dec_ready;
    logic [INST_W-1:0] dec_inst;
    logic [ADDR_W-1:0] dec_pc;

    logic [ADDR_W-1:0] pc_start;
    logic [ADDR_W-1:0] flush_target;
    int                total;
    int                bad;

    fetch_unit #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // PC register: loads the flush target, else steps when the fetch unit advances
    always @(posedge clk or negedge rst) begin
        if (!rst)            pc_in <= pc_start;
        else if (flush)      pc_in <= flush_target;
        else if (pc_advance) pc_in <= pc_in + 1'b1;
    end

    // Synchronous instruction ROM
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 + {27'd0, imem_addr};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("t=%0t check %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    task automatic head(input string tag, input int pc);
        logic [ADDR_W-1:0] p;
        p = ADDR_W'(pc);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd1);
        chk({tag, "_pc"},    64'(dec_pc),    64'(p));
        chk({tag, "_inst"},  64'(dec_inst),  64'(32'hA000_0000 + {27'd0, p}));
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        flush = 1'b0;
        dec_ready = 1'b1;
        pc_start = '0;
        flush_target = '0;
        imem_rdata = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_inst",  64'(dec_inst),  64'd0);
        chk("rst_pc",    64'(dec_pc),    64'd0);
        chk("rst_req",   64'(imem_req),  64'd0);
        chk("rst_adv",   64'(pc_advance),64'd0);

        // Release: first request at pc 0 straight away
        rst = 1'b1;
        #1;
        chk("rel_req",  64'(imem_req),  64'd1);
        chk("rel_addr", 64'(imem_addr), 64'd0);
        cyc();
        chk("lat_n1_valid", 64'(dec_valid), 64'd0);
        cyc();
        head("stream0", 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            head("stream", k);
        end

        // Backpressure: head 4 buffered, 5 in flight; issue must stop
        dec_ready = 1'b0;
        #1;
        chk("bp_req", 64'(imem_req),   64'd0);
        chk("bp_adv", 64'(pc_advance), 64'd0);
        repeat (4) begin
            cyc();
            head("bp_hold", 4);
            chk("bp_req_hold", 64'(imem_req), 64'd0);
        end
        cyc();
        dec_ready = 1'b1;
        #1;
        head("bp_resume", 4);
        chk("bp_resume_req",  64'(imem_req),  64'd1);
        chk("bp_resume_addr", 64'(imem_addr), 64'd6);
        for (int k = 5; k <= 7; k++) begin
            cyc();
            head("resume", k);
        end

        // Flush with one buffered entry (pc 7) and one in flight (pc 8)
        flush_target = 5'd20;
        flush = 1'b1;
        #1;
        chk("fl_req", 64'(imem_req),   64'd0);
        chk("fl_adv", 64'(pc_advance), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_next_valid", 64'(dec_valid), 64'd0);
        chk("fl_next_req",   64'(imem_req),  64'd1);
        chk("fl_next_addr",  64'(imem_addr), 64'd20);
        cyc();
        chk("fl_lat_valid", 64'(dec_valid), 64'd0);
        cyc();
        head("fl_new0", 20);
        cyc();
        head("fl_new1", 21);

        // Flush held for three cycles keeps the unit empty and idle
        flush_target = 5'd25;
        flush = 1'b1;
        #1;
        chk("hold_req0", 64'(imem_req), 64'd0);
        repeat (2) begin
            cyc();
            chk("hold_valid", 64'(dec_valid), 64'd0);
            chk("hold_req",   64'(imem_req),  64'd0);
        end
        cyc();
        flush = 1'b0;
        #1;
        chk("hold_rel_req",  64'(imem_req),  64'd1);
        chk("hold_rel_addr", 64'(imem_addr), 64'd25);
        cyc();
        chk("hold_lat_valid", 64'(dec_valid), 64'd0);
        cyc();
        head("hold_new", 25);

        // PC wrap from 30
        pc_start = 5'd30;
        rst = 1'b0;
        #1;
        chk("wrap_rst_valid", 64'(dec_valid), 64'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("wrap_addr", 64'(imem_addr), 64'd30);
        cyc();
        cyc();
        head("wrap30", 30);
        cyc();
        head("wrap31", 31);
        cyc();
        head("wrap0", 0);
        cyc();
        head("wrap1", 1);

        // Asynchronous reset between edges while streaming
        #2;
        pc_start = 5'd10;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(dec_valid), 64'd0);
        chk("arst_req",   64'(imem_req),  64'd0);
        chk("arst_pc",    64'(dec_pc),    64'd0);
        chk("arst_inst",  64'(dec_inst),  64'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("arst_rel_req",  64'(imem_req),  64'd1);
        chk("arst_rel_addr", 64'(imem_addr), 64'd10);
        cyc();
        chk("arst_lat_valid", 64'(dec_valid), 64'd0);
        cyc();
        head("arst_new0", 10);
        cyc();
        head("arst_new1", 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
